rsa_job_sequencer: RTL and testbench
====================================

Name: rsa_job_sequencer

Overview:
- Upstream feeder for the RSA core controller.
- Accepts one (m, e, n) job on a valid/ready interface and serialises it onto the core's single load strobe and data bus in the order m, e, n.
- Waits for the core's done pulse, captures the result c and the error flag, and holds them on a valid/ready result interface until consumed.
- Exactly one job is in flight at a time.

Parameters:
- DATA_WIDTH, 8, width of m, e, n and c.
- LOAD_ACTIVE, 1'b0, level of core_load meaning "load asserted".
- LOAD_PULSE, 2, cycles core_load is held active per operand; legal range 1..15.
- GAP_CYCLES, 1, cycles core_load is held inactive after each pulse; legal range 1..15 (0 is illegal).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with RSA_SEQ_TIMEOUT_EN.

Ports:
- ctrl_clk, in, 1, clock; rising edge.
- ctrl_rst, in, 1, reset; asynchronous, active-high.
- job_valid, in, 1, job request.
- job_ready, out, 1, sequencer can accept a job.
- job_m, in, DATA_WIDTH, message.
- job_e, in, DATA_WIDTH, exponent.
- job_n, in, DATA_WIDTH, modulus.
- core_load, out, 1, load strobe to core; polarity set by LOAD_ACTIVE.
- core_din, out, DATA_WIDTH, operand to core.
- core_done, in, 1, core completion pulse.
- core_err, in, 1, core error flag.
- core_c, in, DATA_WIDTH, core result.
- res_valid, out, 1, result available.
- res_ready, in, 1, result consumer ready.
- res_c, out, DATA_WIDTH, captured result.
- res_err, out, 1, captured error flag.
- busy, out, 1, job in flight (any state other than IDLE).

Behaviour:
- Reset (async, any state including mid-job):
  - State goes to IDLE; operand registers and counters are cleared.
  - core_load=~LOAD_ACTIVE, core_din=0, res_valid=0, res_c=0, res_err=0, busy=0.
  - job_ready=1 from the first cycle after reset deasserts.
  - The core shares ctrl_rst, so both blocks resynchronise. No partial job survives reset.
- States: IDLE, LD_M, GP_M, LD_E, GP_E, LD_N, GP_N, WAIT_DONE, RESULT, HALT (HALT exists only with the feature).
- Outputs are Moore-decoded from the state register. No input reaches an output combinationally.
- IDLE:
  - job_ready=1.
  - job_valid&&job_ready at edge T latches m, e, n and moves to LD_M. The first load cycle is T+1.
- LD_x:
  - core_load=LOAD_ACTIVE and core_din=operand x.
  - Lasts exactly LOAD_PULSE cycles (counted by a 4-bit counter), then moves to GP_x.
- GP_x:
  - core_load inactive; core_din keeps operand x.
  - Lasts GAP_CYCLES cycles, then moves to the next LD or, after GP_N, to WAIT_DONE.
  - Operand x is presented on core_din for LOAD_PULSE+GAP_CYCLES cycles. core_din changes only on the cycle core_load goes active for the next operand.
- WAIT_DONE:
  - core_load inactive; core_din=0.
  - core_done=1 sampled at edge: capture res_c<=core_c and res_err<=core_err, then move to RESULT.
  - core_done is level-sampled, so a one-cycle pulse is sufficient.
- RESULT:
  - res_valid=1; res_c and res_err are stable.
  - res_valid&&res_ready moves to IDLE. res_ready low holds RESULT indefinitely.
  - A new job can be accepted no earlier than the cycle after the handshake.
- Busy behaviour:
  - job_valid outside IDLE is ignored (job_ready=0); job_* inputs are not sampled.
  - A core_done seen outside WAIT_DONE is ignored.
- Minimum job latency, accept edge to res_valid: 3*(LOAD_PULSE+GAP_CYCLES) + core compute + 1 cycles.
- res_c and res_err keep the last captured values after the handshake, until the next capture or reset.

Optional Feature:
- Macro: RSA_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - On reaching TIMEOUT_CYCLES without core_done, the sequencer moves to HALT.
  - HALT: res_valid=1, res_err=1, res_c=all ones, job_ready=0, busy=1.
  - The result handshake does not leave HALT; only ctrl_rst exits it.
- Not defined:
  - No counter logic; WAIT_DONE waits indefinitely.
  - HALT state is absent.

Test Plan:
- Reset then job m=5, e=3, n=13 with a behavioural core model -> res_valid=1, res_c=8, res_err=0; job_ready=0 from T+1 until after the result handshake.
- LOAD_PULSE=2, GAP_CYCLES=1, accept at edge T -> core_load active at T+1,T+2 (din=m), T+4,T+5 (din=e), T+7,T+8 (din=n); inactive at T+3, T+6, T+9; core_din changes only at T+4 and T+7.
- Job m=9, e=0, n=11 -> res_c=1, res_err=0. Job m=7, e=1, n=0 -> res_c=8'hFF, res_err=1.
- res_ready held low 20 cycles after res_valid -> res_valid, res_c and res_err are stable; job_valid pulses during this time are not accepted; handshake then returns to IDLE next cycle.
- ctrl_rst asserted in GP_E -> all outputs take reset values asynchronously; a full job after release completes correctly.
- With RSA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16 and core_done held 0 -> HALT at 16 cycles after entering WAIT_DONE with res_err=1 and res_c=8'hFF; stays in HALT through handshakes until reset.

Source files
------------

// File: rtl/rsa_job_sequencer_if.sv
// Job, core-load and result signal bundle of the RSA job sequencer.
// The master modport is the sequencer; the slave modport is the job source, core and result consumer.
interface rsa_job_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  job_valid;
    logic                  job_ready;
    logic [DATA_WIDTH-1:0] job_m;
    logic [DATA_WIDTH-1:0] job_e;
    logic [DATA_WIDTH-1:0] job_n;
    logic                  core_load;
    logic [DATA_WIDTH-1:0] core_din;
    logic                  core_done;
    logic                  core_err;
    logic [DATA_WIDTH-1:0] core_c;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_c;
    logic                  res_err;
    logic                  busy;

    modport master (
        input  job_valid, job_m, job_e, job_n, core_done, core_err, core_c, res_ready,
        output job_ready, core_load, core_din, res_valid, res_c, res_err, busy
    );

    modport slave (
        output job_valid, job_m, job_e, job_n, core_done, core_err, core_c, res_ready,
        input  job_ready, core_load, core_din, res_valid, res_c, res_err, busy
    );
endinterface

// File: rtl/rsa_job_sequencer.sv
// Serialises one (m, e, n) job onto the RSA core load strobe and holds the captured result.
// Optional watchdog (WAIT_DONE -> HALT) is enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_job_sequencer #(
    parameter int   DATA_WIDTH     = 8,
    parameter logic LOAD_ACTIVE    = 1'b0,
    parameter int   LOAD_PULSE     = 2,
    parameter int   GAP_CYCLES     = 1,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic                  ctrl_clk,
    input  logic                  ctrl_rst,
    rsa_job_sequencer_if.master   bus,
    output logic [3:0]            o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid, once raised by the producer, is expected to stay high with stable data until then.

    if (LOAD_PULSE < 1 || LOAD_PULSE > 15 || GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("rsa_job_sequencer: LOAD_PULSE/GAP_CYCLES/TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [3:0] {
        IDLE, LD_M, GP_M, LD_E, GP_E, LD_N, GP_N, WAIT_DONE, RESULT
`ifdef RSA_SEQ_TIMEOUT_EN
        , HALT
`endif
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_m, r_e, r_n;
    logic [DATA_WIDTH-1:0] r_res_c;
    logic                  r_res_err;
    logic                  w_ld_end, w_gp_end;
    logic                  w_load, w_job_ready, w_res_valid;
    logic [DATA_WIDTH-1:0] w_din;
    logic                  w_wd_end;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    assign w_wd_end = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_wd_end = 1'b0;
`endif

    assign w_ld_end = (r_cnt == 4'(LOAD_PULSE - 1));
    assign w_gp_end = (r_cnt == 4'(GAP_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (bus.job_valid) w_next = LD_M;
            LD_M:      if (w_ld_end) w_next = GP_M;
            GP_M:      if (w_gp_end) w_next = LD_E;
            LD_E:      if (w_ld_end) w_next = GP_E;
            GP_E:      if (w_gp_end) w_next = LD_N;
            LD_N:      if (w_ld_end) w_next = GP_N;
            GP_N:      if (w_gp_end) w_next = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.core_done) w_next = RESULT;
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (w_wd_end) w_next = HALT;
`endif
            end
            RESULT:    if (bus.res_ready) w_next = IDLE;
`ifdef RSA_SEQ_TIMEOUT_EN
            HALT:      w_next = HALT;
`endif
            default:   w_next = IDLE;
        endcase
    end

    // Moore output decode: operand stays on core_din through its gap phase.
    always_comb begin
        w_load      = ~LOAD_ACTIVE;
        w_din       = '0;
        w_job_ready = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            IDLE:   w_job_ready = 1'b1;
            LD_M:   begin w_load = LOAD_ACTIVE; w_din = r_m; end
            GP_M:   w_din = r_m;
            LD_E:   begin w_load = LOAD_ACTIVE; w_din = r_e; end
            GP_E:   w_din = r_e;
            LD_N:   begin w_load = LOAD_ACTIVE; w_din = r_n; end
            GP_N:   w_din = r_n;
            RESULT: w_res_valid = 1'b1;
`ifdef RSA_SEQ_TIMEOUT_EN
            HALT:   w_res_valid = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_m       <= '0;
            r_e       <= '0;
            r_n       <= '0;
            r_res_c   <= '0;
            r_res_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
            if (r_state == IDLE && bus.job_valid) begin
                r_m <= bus.job_m;
                r_e <= bus.job_e;
                r_n <= bus.job_n;
            end
            if (r_state == WAIT_DONE && bus.core_done) begin
                r_res_c   <= bus.core_c;
                r_res_err <= bus.core_err;
            end else if (r_state == WAIT_DONE && w_wd_end) begin
                r_res_c   <= '1;
                r_res_err <= 1'b1;
            end
        end
    end

`ifdef RSA_SEQ_TIMEOUT_EN
    always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
        if (ctrl_rst)
            r_wd <= '0;
        else if (r_state != WAIT_DONE)
            r_wd <= '0;
        else
            r_wd <= r_wd + 1'b1;
    end
`endif

    assign bus.job_ready = w_job_ready;
    assign bus.core_load = w_load;
    assign bus.core_din  = w_din;
    assign bus.res_valid = w_res_valid;
    assign bus.res_c     = r_res_c;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = (r_state != IDLE);
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Randomised bench for rsa_job_sequencer with a behavioural RSA core and a modexp reference model.
// Watchdog checks are compiled in when RSA_SEQ_TIMEOUT_EN is defined.
module tb_rsa_job_sequencer;
    localparam int   W  = 8;
    localparam logic LA = 1'b0;
    localparam int   P  = 2;
    localparam int   G  = 1;
    localparam int   PG = P + G;
    localparam int   TO = 16;

    logic       ctrl_clk = 1'b0;
    logic       ctrl_rst;
    logic [3:0] dbg_state;
    int         n_total = 0;
    int         n_bad   = 0;
    logic [W:0] exp_q[$];
    bit         core_mute = 1'b0;

    rsa_job_sequencer_if #(.DATA_WIDTH(W)) bus_if ();

    rsa_job_sequencer #(
        .DATA_WIDTH(W), .LOAD_ACTIVE(LA), .LOAD_PULSE(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ctrl_clk(ctrl_clk),
        .ctrl_rst(ctrl_rst),
        .bus(bus_if),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 ctrl_clk = ~ctrl_clk;

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic do_reset();
        ctrl_rst         = 1'b1;
        bus_if.job_valid = 1'b0;
        bus_if.res_ready = 1'b0;
        repeat (2) tick();
        ctrl_rst = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // reference: c = m^e mod n, error with all-ones result when n == 0
    function automatic void modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                   input logic [W-1:0] n, output logic [W-1:0] c,
                                   output logic err);
        int unsigned r;
        if (n == 0) begin
            c   = '1;
            err = 1'b1;
        end else begin
            r = 1 % n;
            for (int i = 0; i < int'(e); i++) r = (r * m) % n;
            c   = W'(r);
            err = 1'b0;
        end
    endfunction

    // behavioural core: grabs an operand at the start of each load pulse, answers later
    initial begin : core_model
        logic [W-1:0] ops [3];
        logic [W-1:0] c;
        logic         err;
        int           slot;
        int           countdown;
        bit           prev_act;
        slot = 0; countdown = 0; prev_act = 1'b0;
        bus_if.core_done = 1'b0;
        bus_if.core_err  = 1'b0;
        bus_if.core_c    = '0;
        forever begin
            tick();
            bus_if.core_done = 1'b0;
            bus_if.core_c    = W'($urandom);
            bus_if.core_err  = 1'($urandom);
            if (ctrl_rst) begin
                slot = 0; countdown = 0; prev_act = 1'b0;
            end else begin
                if (bus_if.core_load == LA && !prev_act) begin
                    ops[slot] = bus_if.core_din;
                    slot++;
                    if (slot == 3) begin
                        slot      = 0;
                        countdown = PG + int'($urandom_range(1, 6));
                    end
                end
                prev_act = (bus_if.core_load == LA);
                if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0 && !core_mute) begin
                        modexp(ops[0], ops[1], ops[2], c, err);
                        bus_if.core_done = 1'b1;
                        bus_if.core_c    = c;
                        bus_if.core_err  = err;
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic start_job(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n);
        int guard = 0;
        while (!bus_if.job_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("accept_ready", bus_if.job_ready, 1);
        bus_if.job_valid = 1'b1;
        bus_if.job_m = m;
        bus_if.job_e = e;
        bus_if.job_n = n;
        tick();
        bus_if.job_valid = 1'b0;
        bus_if.job_m = W'($urandom);
        bus_if.job_e = W'($urandom);
        bus_if.job_n = W'($urandom);
    endtask

    task automatic run_job(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                           input int hold);
        logic [W-1:0] ops [3];
        logic [W-1:0] c;
        logic         err;
        logic [W:0]   exp;
        int           guard;
        ops = '{m, e, n};
        modexp(m, e, n, c, err);
        exp_q.push_back({err, c});
        start_job(m, e, n);
        for (int j = 0; j < 3 * PG; j++) begin
            check("core_load", bus_if.core_load, ((j % PG) < P) ? LA : !LA);
            check("core_din", bus_if.core_din, ops[j / PG]);
            check("busy_rdy", {bus_if.busy, bus_if.job_ready}, 2'b10);
            tick();
        end
        check("wait_din", {bus_if.core_load, bus_if.core_din}, {!LA, W'(0)});
        guard = 0;
        while (!bus_if.res_valid && guard < 200) begin
            check("wait_rdy", bus_if.job_ready, 0);
            tick();
            guard++;
        end
        check("res_valid_seen", bus_if.res_valid, 1);
        exp = exp_q.pop_front();
        check("res", {bus_if.res_err, bus_if.res_c}, exp);
        for (int h = 0; h < hold; h++) begin
            bus_if.job_valid = 1'($urandom);
            tick();
            check("hold", {bus_if.res_valid, bus_if.job_ready, bus_if.res_err, bus_if.res_c},
                  {2'b10, exp});
        end
        bus_if.job_valid = 1'b0;
        bus_if.res_ready = 1'b1;
        tick();
        bus_if.res_ready = 1'b0;
        check("after_hs", {bus_if.res_valid, bus_if.job_ready, bus_if.busy, bus_if.res_err,
                           bus_if.res_c}, {3'b010, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rn;
        bus_if.job_valid = 1'b0;
        bus_if.job_m = '0;
        bus_if.job_e = '0;
        bus_if.job_n = '0;
        bus_if.res_ready = 1'b0;
        do_reset();
        check("reset_state", {bus_if.core_load, bus_if.core_din, bus_if.res_valid, bus_if.res_err,
                              bus_if.res_c, bus_if.busy, bus_if.job_ready},
              {!LA, W'(0), 1'b0, 1'b0, W'(0), 1'b0, 1'b1});

        run_job(8'd5, 8'd3, 8'd13, 0);
        run_job(8'd9, 8'd0, 8'd11, 0);
        run_job(8'd7, 8'd1, 8'd0, 0);
        run_job(W'($urandom), W'($urandom), 8'd251, 20);

        // reset while the exponent gap is on the bus
        start_job(8'h21, 8'h02, 8'h35);
        repeat (PG + P) tick();
        check("gpe_bus", {bus_if.core_load, bus_if.core_din}, {!LA, 8'h02});
        #2 ctrl_rst = 1'b1;
        #1;
        check("rst_async", {bus_if.core_load, bus_if.core_din, bus_if.res_valid, bus_if.res_err,
                            bus_if.res_c, bus_if.busy},
              {!LA, W'(0), 1'b0, 1'b0, W'(0), 1'b0});
        repeat (2) tick();
        ctrl_rst = 1'b0;
        tick();
        check("rst_ready", bus_if.job_ready, 1);
        run_job(8'h21, 8'h02, 8'h35, 0);

        for (int k = 0; k < 8; k++) begin
            rn = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
            run_job(W'($urandom), W'($urandom), rn, int'($urandom_range(0, 3)));
        end

`ifdef RSA_SEQ_TIMEOUT_EN
        core_mute = 1'b1;
        start_job(8'd3, 8'd4, 8'd5);
        repeat (3 * PG + TO - 1) tick();
        check("pre_halt", bus_if.res_valid, 0);
        tick();
        check("halt", {bus_if.res_valid, bus_if.job_ready, bus_if.busy, bus_if.res_err,
                       bus_if.res_c}, {3'b101, 1'b1, {W{1'b1}}});
        bus_if.res_ready = 1'b1;
        repeat (3) tick();
        check("halt_stuck", {bus_if.res_valid, bus_if.job_ready, bus_if.busy, bus_if.res_err,
                             bus_if.res_c}, {3'b101, 1'b1, {W{1'b1}}});
        bus_if.res_ready = 1'b0;
        do_reset();
        core_mute = 1'b0;
        check("halt_rst", {bus_if.res_valid, bus_if.job_ready, bus_if.busy}, 3'b010);
        run_job(8'd3, 8'd4, 8'd5, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
